// File: rtl/ps2_key_event_queue_pkg.sv
// Shared key codes, PS/2 set-2 scan codes and parser types for the key event path.
package ps2_key_event_queue_pkg;

    localparam logic [3:0] key_relesed = 4'd0;
    localparam logic [3:0] key_A       = 4'd1;
    localparam logic [3:0] key_S       = 4'd2;
    localparam logic [3:0] key_W       = 4'd3;
    localparam logic [3:0] key_D       = 4'd4;
    localparam logic [3:0] key_1       = 4'd5;
    localparam logic [3:0] key_2       = 4'd6;
    localparam logic [3:0] key_3       = 4'd7;
    localparam logic [3:0] key_4       = 4'd8;
    localparam logic [3:0] key_esc     = 4'd9;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_3     = 8'h26;
    localparam logic [7:0] SC_4     = 8'h25;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_BRK     = 2'd1,
        PS_EXT     = 2'd2,
        PS_EXT_BRK = 2'd3
    } parse_state_t;

    typedef struct packed {
        logic       pressed;
        logic [3:0] code;
    } key_event_t;

    // key_relesed doubles as "unmapped" since it is never emitted as an event.
    function automatic logic [3:0] map_scan(input logic [7:0] sc);
        case (sc)
            SC_A:    return key_A;
            SC_S:    return key_S;
            SC_W:    return key_W;
            SC_D:    return key_D;
            SC_1:    return key_1;
            SC_2:    return key_2;
            SC_3:    return key_3;
            SC_4:    return key_4;
            SC_ESC:  return key_esc;
            default: return key_relesed;
        endcase
    endfunction

endpackage

// File: rtl/ps2_key_event_queue_fifo.sv
// Generic synchronous show-ahead FIFO; head word is presented whenever not empty.
module key_event_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  rd_data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push_i && (!full_o || do_pop);

    // Zero head while empty keeps the event outputs at 0 after reset.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 set-2 byte parser producing queued make/break key events and a held-key mask.
module ps2_key_event_queue
    import ps2_key_event_queue_pkg::*;
#(
    parameter int KEY_W         = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int IGNORE_REPEAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         scan_valid,
    input  logic [7:0]                   scan_code,
    output logic                         key_valid,
    output logic [KEY_W-1:0]             key_code,
    output logic                         key_pressed,
    input  logic                         key_ready,
    output logic [2**KEY_W-1:0]          held_mask,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow
);

    localparam int NKEYS = 2**KEY_W;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    parse_state_t       state_q, state_d;
    logic [NKEYS-1:0]   held_q, held_d;
    logic               overflow_q, overflow_d;
    key_event_t         ev;
    logic               ev_push;
    logic [3:0]         mapped;
    logic [KEY_W-1:0]   idx;
    logic               fifo_full, fifo_empty;
    logic [KEY_W:0]     head;

    assign mapped = map_scan(scan_code);
    assign idx    = KEY_W'(mapped);

    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        ev_push    = 1'b0;
        ev.pressed = 1'b0;
        ev.code    = mapped;
        if (scan_valid) begin
            case (state_q)
                PS_IDLE: begin
                    if (scan_code == SC_BREAK)     state_d = PS_BRK;
                    else if (scan_code == SC_EXT)  state_d = PS_EXT;
                    else if (mapped != key_relesed) begin
                        ev.pressed = 1'b1;
                        if (!held_q[idx]) begin
                            held_d[idx] = 1'b1;
                            ev_push     = 1'b1;
                        end else if (IGNORE_REPEAT == 0) begin
                            ev_push     = 1'b1;
                        end
                    end
                end
                PS_BRK: begin
                    state_d = PS_IDLE;
                    if (mapped != key_relesed && held_q[idx]) begin
                        held_d[idx] = 1'b0;
                        ev_push     = 1'b1;
                    end
                end
                PS_EXT:  state_d = (scan_code == SC_BREAK) ? PS_EXT_BRK : PS_IDLE;
                default: state_d = PS_IDLE;
            endcase
        end
    end

    // A drop happens only when full and the head is not leaving this cycle.
    assign overflow_d = overflow_q | (ev_push && fifo_full && !(key_valid && key_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PS_IDLE;
            held_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            overflow_q <= overflow_d;
        end
    end

    key_event_fifo #(
        .W     (KEY_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (ev_push),
        .wr_data_i ({ev.pressed, KEY_W'(ev.code)}),
        .pop_i     (key_ready),
        .rd_data_o (head),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign key_valid   = !fifo_empty;
    assign key_pressed = head[KEY_W];
    assign key_code    = head[KEY_W-1:0];
    assign held_mask   = held_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Scoreboarded bench: expected events queued at stimulus time, checked as they are popped.
module tb_ps2_key_event_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_valid;
    logic [7:0]  scan_code;
    logic        key_ready;
    logic        key_valid, key_pressed, overflow;
    logic [3:0]  key_code;
    logic [15:0] held_mask;
    logic [3:0]  fifo_count;

    // Second instance with repeats enabled, always draining.
    logic        ready0 = 1'b1;
    logic        key_valid0, key_pressed0, overflow0;
    logic [3:0]  key_code0;
    logic [15:0] held_mask0;
    logic [3:0]  fifo_count0;

    int vectors = 0;
    int miscompares = 0;
    int ev0_cnt = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    ps2_key_event_queue #(.KEY_W(4), .FIFO_DEPTH(8), .IGNORE_REPEAT(1)) dut (
        .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_code(scan_code),
        .key_valid(key_valid), .key_code(key_code), .key_pressed(key_pressed),
        .key_ready(key_ready), .held_mask(held_mask), .fifo_count(fifo_count),
        .overflow(overflow)
    );

    ps2_key_event_queue #(.KEY_W(4), .FIFO_DEPTH(8), .IGNORE_REPEAT(0)) dut0 (
        .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_code(scan_code),
        .key_valid(key_valid0), .key_code(key_code0), .key_pressed(key_pressed0),
        .key_ready(ready0), .held_mask(held_mask0), .fifo_count(fifo_count0),
        .overflow(overflow0)
    );

    // Pop happens at the next posedge; check the head that is about to leave.
    always @(negedge clk) begin
        if (!rst && key_valid && key_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event got=%b expected none", {key_pressed, key_code});
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if ({key_pressed, key_code} !== e) begin
                    miscompares++;
                    $display("FAIL event got=%b expected=%b", {key_pressed, key_code}, e);
                end
            end
        end
        if (!rst && key_valid0) ev0_cnt++;
    end

    task automatic send(input logic [7:0] b);
        scan_valid = 1'b1;
        scan_code  = b;
        @(posedge clk); #1;
        scan_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        ev0_cnt = 0;
    endtask

    task automatic test_reset();
        scan_valid = 1'b0; scan_code = 8'h00; key_ready = 1'b0;
        do_reset();
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL rst_key_valid got=%b exp=0", key_valid); end
        vectors++; if (key_code !== 4'd0) begin miscompares++; $display("FAIL rst_key_code got=%0d exp=0", key_code); end
        vectors++; if (key_pressed !== 1'b0) begin miscompares++; $display("FAIL rst_key_pressed got=%b exp=0", key_pressed); end
        vectors++; if (held_mask !== 16'h0) begin miscompares++; $display("FAIL rst_held got=%h exp=0", held_mask); end
        vectors++; if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_press_release();
        do_reset();
        key_ready = 1'b1;
        exp_q.push_back({1'b1, 4'd1});
        send(8'h1C);
        vectors++; if (key_valid !== 1'b1) begin miscompares++; $display("FAIL pr_latency key_valid got=%b exp=1", key_valid); end
        vectors++; if (held_mask !== 16'h0002) begin miscompares++; $display("FAIL pr_held_press got=%h exp=0002", held_mask); end
        send(8'hF0);
        exp_q.push_back({1'b0, 4'd1});
        send(8'h1C);
        vectors++; if (held_mask !== 16'h0000) begin miscompares++; $display("FAIL pr_held_release got=%h exp=0000", held_mask); end
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL pr_drain left=%0d exp=0", exp_q.size()); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL pr_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_repeat();
        do_reset();
        key_ready = 1'b1;
        exp_q.push_back({1'b1, 4'd3});
        send(8'h1D); send(8'h1D); send(8'h1D); send(8'hF0);
        exp_q.push_back({1'b0, 4'd3});
        send(8'h1D);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rep_drain left=%0d exp=0", exp_q.size()); end
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL rep_extra_events key_valid got=%b exp=0", key_valid); end
        vectors++; if (ev0_cnt != 4) begin miscompares++; $display("FAIL rep_no_ignore events got=%0d exp=4", ev0_cnt); end
    endtask

    task automatic test_extended();
        do_reset();
        key_ready = 1'b1;
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        exp_q.push_back({1'b1, 4'd9});
        send(8'h76);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL ext_drain left=%0d exp=0", exp_q.size()); end
        vectors++; if (held_mask !== 16'h0200) begin miscompares++; $display("FAIL ext_held got=%h exp=0200", held_mask); end
    endtask

    task automatic test_overflow();
        logic [7:0] sc [9] = '{8'h1C, 8'h1B, 8'h1D, 8'h23, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h76};
        do_reset();
        key_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back({1'b1, 4'(i + 1)});
            send(sc[i]);
        end
        vectors++; if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL ovf_count got=%0d exp=8", fifo_count); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        vectors++; if (held_mask !== 16'h03FE) begin miscompares++; $display("FAIL ovf_held got=%h exp=03FE", held_mask); end
        key_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL ovf_drain left=%0d exp=0", exp_q.size()); end
        vectors++; if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL ovf_empty got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sc [8] = '{8'h1C, 8'h1B, 8'h1D, 8'h23, 8'h16, 8'h1E, 8'h26, 8'h25};
        do_reset();
        key_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({1'b1, 4'(i + 1)});
            send(sc[i]);
        end
        vectors++; if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL b2b_full got=%0d exp=8", fifo_count); end
        // Pop and push on the same edge while full.
        key_ready  = 1'b1;
        scan_valid = 1'b1;
        scan_code  = 8'h76;
        exp_q.push_back({1'b1, 4'd9});
        @(posedge clk); #1;
        scan_valid = 1'b0;
        key_ready  = 1'b0;
        vectors++; if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL b2b_count got=%0d exp=8", fifo_count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
        vectors++; if (key_code !== 4'd2) begin miscompares++; $display("FAIL b2b_head got=%0d exp=2", key_code); end
        key_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_drain left=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        key_ready = 1'b1;
        send(8'hF0);
        do_reset();
        exp_q.push_back({1'b1, 4'd1});
        send(8'h1C);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rmid_drain left=%0d exp=0", exp_q.size()); end
        vectors++; if (held_mask !== 16'h0002) begin miscompares++; $display("FAIL rmid_held got=%h exp=0002", held_mask); end
    endtask

    initial begin
        rst = 1'b1;
        scan_valid = 1'b0;
        scan_code = 8'h00;
        key_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_press_release();
        test_repeat();
        test_extended();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_queue.md
# ps2_key_event_queue

Converts a stream of PS/2 set-2 scan-code bytes into press and release events using the package key codes (key_A … key_esc), and tracks which keys are currently held. Events are buffered in a parametrised FIFO so that the game and menu FSMs can consume them at their own pace. The block sits between the PS/2 receiver and the menu/game control logic, replacing single-register key latching with a queued, lossless-until-full event path.

## Interface
- KEY_W, 4, width of a key code; must be ≥ 4 so that every package key code fits.
- FIFO_DEPTH, 8, number of queued events; power of two, ≥ 2.
- IGNORE_REPEAT, 1, 1 = typematic make codes for an already-held key produce no event; 0 = each repeat pushes another press event.

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- scan_valid  in  1  one-cycle strobe, scan_code valid
- scan_code  in  8  received PS/2 byte
- key_valid  out  1  FIFO not empty; head event presented
- key_code  out  KEY_W  head event key code
- key_pressed  out  1  head event: 1 = make, 0 = break
- key_ready  in  1  consumer pop; effective only when key_valid=1
- held_mask  out  2**KEY_W  bit k = key code k currently held
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued events
- overflow  out  1  sticky; an event was dropped

## Operation
- Mapping (set 2 → package code): 1C→key_A, 1B→key_S, 1D→key_W, 23→key_D, 16→key_1, 1E→key_2, 26→key_3, 25→key_4, 76→key_esc. Every other byte is unmapped and produces no event. key_relesed (0) is never emitted and held_mask[0] stays 0.
- Parser FSM, advanced only on scan_valid:
  - IDLE: F0→BRK; E0→EXT; mapped code→make; anything else stays in IDLE.
  - BRK: any byte→IDLE; a mapped code→break.
  - EXT: F0→EXT_BRK; any other byte is discarded →IDLE.
  - EXT_BRK: any byte is discarded →IDLE. Extended keys are ignored entirely.
- Make for key k: if held_mask[k]=0, set the bit and push {1,k}. If already held, push {1,k} only when IGNORE_REPEAT=0.
- Break for key k: if held_mask[k]=1, clear the bit and push {0,k}. Otherwise no event.
- held_mask updates even when the push is dropped, so held state always matches the keyboard.
- FIFO is show-ahead: key_code/key_pressed are valid whenever key_valid=1. Pop on key_valid && key_ready.
- Push while full without a simultaneous pop drops the event and sets overflow. Only rst clears overflow.
- Push and pop in the same cycle: both happen and count is unchanged. This applies when full, and when empty only if key_valid was already 1.

## Timing
- Reset values: FSM=IDLE, key_valid=0, key_code=0, key_pressed=0, held_mask=0, fifo_count=0, overflow=0. FIFO contents are don't-care.
- Latency: mapped byte strobed at edge N pushes at edge N. If the FIFO was empty, key_valid=1 and the head is valid after edge N, in cycle N+1.
- A pop at edge M shows the next head (or key_valid=0) from cycle M+1.
- held_mask and overflow are registered and change on the same edge as the push decision.
- scan_valid can be asserted every cycle; the block has no backpressure to the PS/2 side.
- rst asserted mid-sequence (e.g. in BRK) returns to IDLE, so the next byte is parsed as a fresh code.

## Structure
- The package gains: scan-code constants SC_A, SC_S, SC_W, SC_D, SC_1, SC_2, SC_3, SC_4, SC_ESC, SC_BREAK=8'hF0 and SC_EXT=8'hE0; a parser state enum; and a key-event struct {pressed, code}. The existing key_* codes are reused unchanged.
- Sub-module key_event_fifo: a generic synchronous show-ahead FIFO parametrised by width and depth, with count and full/empty outputs. The parser, mapping and held_mask logic stay in the top module.

## Test plan
- Reset, then bytes 1C, F0, 1C with key_ready=1 → events {1,key_A} then {0,key_A}; held_mask bit 1 goes 1 then 0; overflow=0.
- IGNORE_REPEAT=1, bytes 1D,1D,1D,F0,1D → exactly 2 events (press/release key_W). With IGNORE_REPEAT=0 → 4 events.
- Bytes E0,75,E0,F0,75 then 76 → the only event is {1,key_esc}; held_mask=0x200.
- key_ready=0, FIFO_DEPTH=8, 9 distinct press events → fifo_count=8, overflow=1. Held bits for all 9 keys are set, and pops return the first 8 events in order.
- FIFO full, key_ready=1 while a new make arrives in the same cycle → count stays 8, the head advances, and the new event is stored with no overflow.
- F0 followed by rst, then 1C → {1,key_A} is pushed (not a break) and held_mask bit 1 is set.
